// File: rtl/idex_stage_if.sv
// ID/EX stage bus: decoded instruction fields in from decode, registered stage
// contents plus hazard status out to execute and the forwarding unit.
interface idex_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  logic              ifid_valid;
  logic [REG_W-1:0]  ifid_rs;
  logic [REG_W-1:0]  ifid_rt;
  logic [REG_W-1:0]  ifid_rd;
  logic [DATA_W-1:0] ifid_rs_data;
  logic [DATA_W-1:0] ifid_rt_data;
  logic [DATA_W-1:0] ifid_imm;
  logic              ifid_regwrite;
  logic              ifid_memread;
  logic              ifid_memwrite;
  logic              ifid_memtoreg;
  logic              ifid_alusrc;
  logic [3:0]        ifid_aluop;
  logic              flush;
  logic              hold;

  logic              idex_valid;
  logic [REG_W-1:0]  idex_rs;
  logic [REG_W-1:0]  idex_rt;
  logic [REG_W-1:0]  idex_rd;
  logic [DATA_W-1:0] idex_rs_data;
  logic [DATA_W-1:0] idex_rt_data;
  logic [DATA_W-1:0] idex_imm;
  logic              idex_regwrite;
  logic              idex_memread;
  logic              idex_memwrite;
  logic              idex_memtoreg;
  logic              idex_alusrc;
  logic [3:0]        idex_aluop;
  logic              stall;
  logic [15:0]       hazard_count;

  modport master (
    output ifid_valid, ifid_rs, ifid_rt, ifid_rd, ifid_rs_data, ifid_rt_data,
           ifid_imm, ifid_regwrite, ifid_memread, ifid_memwrite, ifid_memtoreg,
           ifid_alusrc, ifid_aluop, flush, hold,
    input  idex_valid, idex_rs, idex_rt, idex_rd, idex_rs_data, idex_rt_data,
           idex_imm, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
           idex_alusrc, idex_aluop, stall, hazard_count
  );

  modport slave (
    input  ifid_valid, ifid_rs, ifid_rt, ifid_rd, ifid_rs_data, ifid_rt_data,
           ifid_imm, ifid_regwrite, ifid_memread, ifid_memwrite, ifid_memtoreg,
           ifid_alusrc, ifid_aluop, flush, hold,
    output idex_valid, idex_rs, idex_rt, idex_rd, idex_rs_data, idex_rt_data,
           idex_imm, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
           idex_alusrc, idex_aluop, stall, hazard_count
  );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, external hold and a saturating bubble counter.
module idex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  idex_stage_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic [3:0]        aluop;
  } stage_t;

  stage_t      q;
  stage_t      d_load;
  logic [15:0] hazard_cnt;
  logic        stall_c;

  // Address 0 is hardwired zero, so a load targeting it never creates a hazard.
  always_comb begin
    stall_c = q.valid & q.memread & bus.ifid_valid & (q.rt != '0) &
              ((q.rt == bus.ifid_rs) | (q.rt == bus.ifid_rt));
  end

  // Invalid slots still carry their data but must never write state.
  always_comb begin
    d_load          = '0;
    d_load.valid    = bus.ifid_valid;
    d_load.rs       = bus.ifid_rs;
    d_load.rt       = bus.ifid_rt;
    d_load.rd       = bus.ifid_rd;
    d_load.rs_data  = bus.ifid_rs_data;
    d_load.rt_data  = bus.ifid_rt_data;
    d_load.imm      = bus.ifid_imm;
    d_load.regwrite = bus.ifid_regwrite & bus.ifid_valid;
    d_load.memread  = bus.ifid_memread  & bus.ifid_valid;
    d_load.memwrite = bus.ifid_memwrite & bus.ifid_valid;
    d_load.memtoreg = bus.ifid_memtoreg;
    d_load.alusrc   = bus.ifid_alusrc;
    d_load.aluop    = bus.ifid_aluop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q          <= '0;
      hazard_cnt <= '0;
    end else if (bus.flush) begin
      q <= '0;
    end else if (bus.hold) begin
      q          <= q;
      hazard_cnt <= hazard_cnt;
    end else if (stall_c) begin
      q <= '0;
      if (hazard_cnt != '1) begin
        hazard_cnt <= hazard_cnt + 16'd1;
      end
    end else begin
      q <= d_load;
    end
  end

  assign bus.idex_valid    = q.valid;
  assign bus.idex_rs       = q.rs;
  assign bus.idex_rt       = q.rt;
  assign bus.idex_rd       = q.rd;
  assign bus.idex_rs_data  = q.rs_data;
  assign bus.idex_rt_data  = q.rt_data;
  assign bus.idex_imm      = q.imm;
  assign bus.idex_regwrite = q.regwrite;
  assign bus.idex_memread  = q.memread;
  assign bus.idex_memwrite = q.memwrite;
  assign bus.idex_memtoreg = q.memtoreg;
  assign bus.idex_alusrc   = q.alusrc;
  assign bus.idex_aluop    = q.aluop;
  assign bus.stall         = stall_c;
  assign bus.hazard_count  = hazard_cnt;
endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed vector table, counter saturation sequence and
// randomized traffic against a behavioural stage model.
module tb_idex_stage;
  localparam int DW = 16;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  idex_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();
  idex_stage #(.DATA_W(DW), .REG_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          alusrc;
    logic [3:0]    aluop;
  } in_t;

  typedef struct {
    logic          v;
    logic [RW-1:0] rs, rt, rd;
    logic [DW-1:0] rsd;
    logic          rw, mr, fl, hd;
    logic          x_stall, x_v;
    logic [RW-1:0] x_rs, x_rt, x_rd;
    logic [DW-1:0] x_rsd;
    logic          x_rw, x_mr;
    logic [15:0]   x_cnt;
  } vec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  in_t         m;
  logic [15:0] m_cnt;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, input int rs, input int rt, input int rd,
                              input int rsd, input int rw, input int mr, input int fl,
                              input int hd, input int xs, input int xv, input int xrs,
                              input int xrt, input int xrd, input int xrsd, input int xrw,
                              input int xmr, input int xcnt);
    vec_t t;
    t.v = 1'(v);  t.rs = 4'(rs); t.rt = 4'(rt); t.rd = 4'(rd); t.rsd = 16'(rsd);
    t.rw = 1'(rw); t.mr = 1'(mr); t.fl = 1'(fl); t.hd = 1'(hd);
    t.x_stall = 1'(xs); t.x_v = 1'(xv); t.x_rs = 4'(xrs); t.x_rt = 4'(xrt);
    t.x_rd = 4'(xrd); t.x_rsd = 16'(xrsd); t.x_rw = 1'(xrw); t.x_mr = 1'(xmr);
    t.x_cnt = 16'(xcnt);
    return t;
  endfunction

  task automatic drive(input in_t r, input logic fl, input logic hd);
    bus.ifid_valid    = r.valid;
    bus.ifid_rs       = r.rs;
    bus.ifid_rt       = r.rt;
    bus.ifid_rd       = r.rd;
    bus.ifid_rs_data  = r.rs_data;
    bus.ifid_rt_data  = r.rt_data;
    bus.ifid_imm      = r.imm;
    bus.ifid_regwrite = r.regwrite;
    bus.ifid_memread  = r.memread;
    bus.ifid_memwrite = r.memwrite;
    bus.ifid_memtoreg = r.memtoreg;
    bus.ifid_alusrc   = r.alusrc;
    bus.ifid_aluop    = r.aluop;
    bus.flush         = fl;
    bus.hold          = hd;
  endtask

  function automatic in_t dut_out();
    in_t o;
    o.valid = bus.idex_valid;     o.rs = bus.idex_rs;         o.rt = bus.idex_rt;
    o.rd = bus.idex_rd;           o.rs_data = bus.idex_rs_data;
    o.rt_data = bus.idex_rt_data; o.imm = bus.idex_imm;
    o.regwrite = bus.idex_regwrite; o.memread = bus.idex_memread;
    o.memwrite = bus.idex_memwrite; o.memtoreg = bus.idex_memtoreg;
    o.alusrc = bus.idex_alusrc;   o.aluop = bus.idex_aluop;
    return o;
  endfunction

  function automatic in_t rand_in();
    in_t r;
    r.valid    = 1'($urandom_range(0, 7) != 0);
    r.rs       = 4'($urandom_range(0, 3));
    r.rt       = 4'($urandom_range(0, 3));
    r.rd       = 4'($urandom);
    r.rs_data  = 16'($urandom);
    r.rt_data  = 16'($urandom);
    r.imm      = 16'($urandom);
    r.regwrite = 1'($urandom);
    r.memread  = 1'($urandom_range(0, 2) == 0);
    r.memwrite = 1'($urandom);
    r.memtoreg = 1'($urandom);
    r.alusrc   = 1'($urandom);
    r.aluop    = 4'($urandom);
    return r;
  endfunction

  // A load in EX blocks a valid instruction in ID that reads its (nonzero) target.
  function automatic logic load_use(input in_t ex, input in_t id);
    logic reads_target;
    reads_target = (id.rs == ex.rt) || (id.rt == ex.rt);
    return ex.valid && ex.memread && id.valid && (ex.rt != 0) && reads_target;
  endfunction

  function automatic void model_edge(input in_t id, input logic rst, input logic fl,
                                     input logic hd, input logic st);
    if (!rst) begin
      m = '0;
      m_cnt = 16'd0;
    end else if (fl) begin
      m = '0;
    end else if (hd) begin
      m = m;
    end else if (st) begin
      m = '0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m = id;
      if (!id.valid) begin
        m.regwrite = 1'b0;
        m.memread  = 1'b0;
        m.memwrite = 1'b0;
      end
    end
  endfunction

  task automatic run_vec(input vec_t t, input string nm);
    in_t r;
    r = '0;
    r.valid = t.v; r.rs = t.rs; r.rt = t.rt; r.rd = t.rd; r.rs_data = t.rsd;
    r.rt_data = 16'h00F0; r.regwrite = t.rw; r.memread = t.mr;
    drive(r, t.fl, t.hd);
    #1;
    chk({nm, " stall"}, 128'(bus.stall), 128'(t.x_stall));
    @(posedge clk);
    #1;
    chk({nm, " fields"},
        128'({bus.idex_valid, bus.idex_rs, bus.idex_rt, bus.idex_rd, bus.idex_rs_data,
              bus.idex_regwrite, bus.idex_memread}),
        128'({t.x_v, t.x_rs, t.x_rt, t.x_rd, t.x_rsd, t.x_rw, t.x_mr}));
    chk({nm, " count"}, 128'(bus.hazard_count), 128'(t.x_cnt));
  endtask

  task automatic reset_check(input string nm);
    rst_n = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      drive(rand_in(), 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
    end
    chk({nm, " outputs"}, 128'(dut_out()), 128'(0));
    chk({nm, " count"}, 128'(bus.hazard_count), 128'(0));
    rst_n = 1'b1;
    drive(rand_in(), 1'b0, 1'b0);
    #1;
    chk({nm, " stall"}, 128'(bus.stall), 128'(0));
    m = '0;
    m_cnt = 16'd0;
  endtask

  vec_t tbl[16];
  vec_t sat[4];

  initial begin
    //            v rs rt rd rsd     rw mr fl hd | st v rs rt rd rsd     rw mr cnt
    tbl[0]  = mk(1, 3, 4, 5, 'h1234, 1, 0, 0, 0,  0, 1, 3, 4, 5, 'h1234, 1, 0, 0);
    tbl[1]  = mk(1, 1, 2, 2, 0,      1, 1, 0, 0,  0, 1, 1, 2, 2, 0,      1, 1, 0);
    tbl[2]  = mk(1, 2, 6, 7, 'h55,   1, 0, 0, 0,  1, 0, 0, 0, 0, 0,      0, 0, 1);
    tbl[3]  = mk(1, 2, 6, 7, 'h55,   1, 0, 0, 0,  0, 1, 2, 6, 7, 'h55,   1, 0, 1);
    tbl[4]  = mk(1, 1, 0, 0, 0,      1, 1, 0, 0,  0, 1, 1, 0, 0, 0,      1, 1, 1);
    tbl[5]  = mk(1, 0, 0, 3, 9,      1, 0, 0, 0,  0, 1, 0, 0, 3, 9,      1, 0, 1);
    tbl[6]  = mk(1, 5, 2, 2, 0,      1, 1, 0, 0,  0, 1, 5, 2, 2, 0,      1, 1, 1);
    tbl[7]  = mk(1, 9, 2, 4, 0,      1, 0, 1, 1,  1, 0, 0, 0, 0, 0,      0, 0, 1);
    tbl[8]  = mk(1, 0, 3, 3, 0,      1, 1, 0, 0,  0, 1, 0, 3, 3, 0,      1, 1, 1);
    tbl[9]  = mk(1, 3, 8, 1, 'h77,   1, 0, 0, 1,  1, 1, 0, 3, 3, 0,      1, 1, 1);
    tbl[10] = mk(1, 3, 9, 2, 'h78,   0, 1, 0, 1,  1, 1, 0, 3, 3, 0,      1, 1, 1);
    tbl[11] = mk(1, 3, 7, 6, 'h79,   1, 0, 0, 1,  1, 1, 0, 3, 3, 0,      1, 1, 1);
    tbl[12] = mk(1, 3, 8, 1, 'h77,   1, 0, 0, 0,  1, 0, 0, 0, 0, 0,      0, 0, 2);
    tbl[13] = mk(1, 3, 8, 1, 'h77,   1, 0, 0, 0,  0, 1, 3, 8, 1, 'h77,   1, 0, 2);
    tbl[14] = mk(0, 1, 2, 3, 'hAAAA, 1, 1, 0, 0,  0, 0, 1, 2, 3, 'hAAAA, 0, 0, 2);
    tbl[15] = mk(1, 2, 2, 0, 1,      0, 0, 0, 0,  0, 1, 2, 2, 0, 1,      0, 0, 2);

    sat[0]  = mk(1, 0, 5, 5, 0,      1, 1, 0, 0,  0, 1, 0, 5, 5, 0,      1, 1, 'hFFFE);
    sat[1]  = mk(1, 5, 1, 1, 2,      1, 0, 0, 0,  1, 0, 0, 0, 0, 0,      0, 0, 'hFFFF);
    sat[2]  = mk(1, 0, 5, 5, 0,      1, 1, 0, 0,  0, 1, 0, 5, 5, 0,      1, 1, 'hFFFF);
    sat[3]  = mk(1, 5, 1, 1, 2,      1, 0, 0, 0,  1, 0, 0, 0, 0, 0,      0, 0, 'hFFFF);

    rst_n = 1'b0;
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    reset_check("reset0");

    for (int unsigned i = 0; i < 16; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Reaching 0xFFFF organically needs >100k cycles; preload near the top instead.
    dut.hazard_cnt = 16'hFFFE;
    for (int unsigned i = 0; i < 4; i++) begin
      run_vec(sat[i], $sformatf("sat%0d", i));
    end

    reset_check("reset1");

    for (int unsigned i = 0; i < 3000; i++) begin
      in_t  r;
      logic fl, hd, rs, st;
      r  = rand_in();
      fl = 1'($urandom_range(0, 15) == 0);
      hd = 1'($urandom_range(0, 7) == 0);
      rs = 1'($urandom_range(0, 63) != 0);
      rst_n = rs;
      drive(r, fl, hd);
      #1;
      st = load_use(m, r);
      chk($sformatf("rnd%0d stall", i), 128'(bus.stall), 128'(st));
      @(posedge clk);
      model_edge(r, rs, fl, hd, st);
      #1;
      chk($sformatf("rnd%0d fields", i), 128'(dut_out()), 128'(m));
      chk($sformatf("rnd%0d count", i), 128'(bus.hazard_count), 128'(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 16-bit CPU. It captures decoded operands, register addresses and control bits from the decode stage every cycle, and presents them to the execute stage and the forwarding unit (`idex_rs`, `idex_rt`). On a load-use hazard it inserts one bubble and requests a front-end stall. It also supports a branch flush, an external hold, and a saturating hazard counter for performance debug.

## Interface
Parameters:
- `DATA_W`, 16: datapath width.
- `REG_W`, 4: register-address width; register 0 (`r_zero`) is hardwired zero.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ifid_valid` in 1: decode-stage instruction valid.
- `ifid_rs`, `ifid_rt`, `ifid_rd` in REG_W: decoded register addresses.
- `ifid_rs_data`, `ifid_rt_data` in DATA_W: register-file read data.
- `ifid_imm` in DATA_W: sign-extended immediate.
- `ifid_regwrite`, `ifid_memread`, `ifid_memwrite`, `ifid_memtoreg`, `ifid_alusrc` in 1: control bits.
- `ifid_aluop` in 4: ALU operation.
- `flush` in 1: branch taken; squash the instruction entering EX.
- `hold` in 1: external stall (memory busy); freeze the register.
- `idex_valid` out 1; `idex_rs`, `idex_rt`, `idex_rd` out REG_W; `idex_rs_data`, `idex_rt_data`, `idex_imm` out DATA_W; `idex_regwrite`, `idex_memread`, `idex_memwrite`, `idex_memtoreg`, `idex_alusrc` out 1; `idex_aluop` out 4: registered stage contents.
- `stall` out 1: load-use hazard. PC and IF/ID must not advance.
- `hazard_count` out 16: number of load-use bubbles inserted, saturating.

## Operation
- Hazard (combinational): `stall` = `idex_valid & idex_memread & ifid_valid & (idex_rt != 0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt))`.
- Per-edge update priority, highest first:
  1. `!rst_n`: all outputs 0, `hazard_count` = 0.
  2. `flush`: bubble (see below). Flush overrides hold and stall.
  3. `hold`: all registered fields retain their value. `hazard_count` retains its value.
  4. `stall`: bubble. `hazard_count` += 1, saturating at 0xFFFF.
  5. Otherwise: load all `ifid_*` fields. `idex_valid` <= `ifid_valid`.
- Bubble: every `idex_*` field, including `idex_valid`, is written to 0. Register address 0 guarantees the forwarding unit sees no match.
- If `ifid_valid` = 0 on a normal load, the data fields load as-is, but `idex_regwrite`, `idex_memread` and `idex_memwrite` are forced to 0.
- `stall` is an output only. It depends on current registered state and the `ifid_*` inputs, and it is not gated by `hold` or `flush`. The upstream stage ignores `stall` when `flush` = 1.
- Each stall lasts exactly one cycle. After the bubble, `idex_memread` = 0, so `stall` deasserts unless `hold` froze the load in place.

## Timing
- Latency: one cycle from `ifid_*` to `idex_*`.
- `stall` has zero-cycle combinational latency. It asserts in the same cycle the dependent instruction sits in ID.
- Reset mid-operation: the next edge with `rst_n` = 0 clears everything regardless of `flush` or `hold`. `stall` reads 0 from the first cycle after reset.
- Simultaneous `hold` and `stall`: the register holds, the load stays in EX, and `stall` remains asserted. The counter does not increment until the bubble is actually inserted.
- Counter wrap: at 0xFFFF, further bubbles leave the counter at 0xFFFF.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles with random inputs -> all `idex_*` outputs = 0, `stall` = 0, `hazard_count` = 0.
- Pass-through: `ifid_rs` = 3, `ifid_rt` = 4, `ifid_rd` = 5, `ifid_rs_data` = 0x1234, `ifid_regwrite` = 1, `ifid_valid` = 1 -> the next cycle shows the same values on `idex_*` and `idex_valid` = 1.
- Load-use: load with `idex_rt` = 2 and `idex_memread` = 1 in EX; next instruction has `ifid_rs` = 2 -> `stall` = 1 that cycle; next edge gives `idex_valid` = 0, `idex_regwrite` = 0, `hazard_count` = 1; following cycle `stall` = 0 and the instruction loads. Repeat with `idex_rt` = 0 -> `stall` stays 0.
- Flush priority: set `stall`, `hold` and `flush` all to 1 -> next edge produces a bubble, `hazard_count` unchanged.
- Hold: `hold` = 1 for 3 cycles while the `ifid_*` inputs change -> `idex_*` stays constant. With a pending load-use hazard, `stall` stays 1 throughout and `hazard_count` increments only once, after `hold` drops.
- Saturation: preload the count by forcing 65535 hazards (or backdoor) -> after one more bubble, `hazard_count` = 0xFFFF.
